rnd_mod_gen: RTL

- Parametrised random-modulus generator. Produces a stream of uniformly distributed values in [0, Range-1] for randomised hash-slot, port and bucket selection in the NTS lookup/CAM logic.
- Contains its own Galois LFSR with run-time seed load and a run-time modulus. Uses multiplicative range mapping instead of a fixed threshold ladder.
- Output is a registered 2-stage valid/ready stream with an accepted-sample counter.

---
 rtl/rnd_mod_gen.sv | 83 ++++++++
 1 files changed

// File: rtl/rnd_mod_gen.sv
// Random-modulus generator: Galois LFSR scaled into [0, N-1] by
// multiplication, delivered through a 2-stage valid/ready pipeline.
module rnd_mod_gen #(
   parameter int            P    = 16,
   parameter int            R    = 2,
   parameter logic [P-1:0]  TAPS = 16'hB400,
   parameter logic [P-1:0]  SEED = 16'hACE1,
   parameter int            CW   = 16
) (
   input  logic          Clk,
   input  logic          Rst,
   input  logic          SeedLoad,
   input  logic [P-1:0]  Seed,
   input  logic [R:0]    Range,
   output logic          Out_Valid,
   input  logic          Out_Ready,
   output logic [R-1:0]  Mod,
   output logic [CW-1:0] Count
);

   localparam int PW = P + R + 1;
   localparam logic [R:0] MAXN = {1'b1, {R{1'b0}}};
   localparam logic [R:0] ONE  = {{R{1'b0}}, 1'b1};

   logic [P-1:0]  lfsr;
   logic [P-1:0]  lfsr_next;
   logic [P-1:0]  seed_eff;
   logic [R:0]    neff;
   logic [PW-1:0] prod_next;
   logic [PW-1:0] prod;
   logic          v1;
   logic          adv1;
   logic          adv2;

   assign adv2 = !Out_Valid || Out_Ready;
   assign adv1 = !v1 || adv2;

   // Zero would lock the LFSR, so fall back to the reset seed.
   assign seed_eff = (Seed == '0) ? SEED : Seed;

   always_comb begin
      lfsr_next = lfsr >> 1;
      if (lfsr[0]) lfsr_next = (lfsr >> 1) ^ TAPS;
   end

   always_comb begin
      neff = Range;
      if (Range == '0) neff = ONE;
      else if (Range > MAXN) neff = MAXN;
   end

   assign prod_next = PW'(lfsr) * PW'(neff);

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         lfsr      <= SEED;
         v1        <= 1'b0;
         prod      <= '0;
         Out_Valid <= 1'b0;
         Mod       <= '0;
         Count     <= '0;
      end else begin
         if (Out_Valid && Out_Ready) Count <= Count + 1'b1;
         if (SeedLoad) begin
            lfsr      <= seed_eff;
            v1        <= 1'b0;
            Out_Valid <= 1'b0;
         end else begin
            if (adv2) begin
               Out_Valid <= v1;
               if (v1) Mod <= R'(prod >> P);
            end
            // Source never stalls: stage 1 refills whenever it may.
            if (adv1) begin
               v1   <= 1'b1;
               prod <= prod_next;
               lfsr <= lfsr_next;
            end
         end
      end
   end

endmodule
